// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: fetch-PC owner and in-order prefetch queue presenting {pc, pc+4, instr} to IF/ID
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] NOP      = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       o_imem_req,
    output logic [31:0]                o_imem_addr,
    input  logic [31:0]                i_imem_rdata,
    input  logic                       i_imem_rvalid,
    input  logic                       i_redirect,
    input  logic [31:0]                i_redirect_pc,
    input  logic                       i_stall,
    output logic                       o_ifid_valid,
    output logic [31:0]                o_ifid_pc,
    output logic [31:0]                o_ifid_npc,
    output logic [31:0]                o_ifid_instr,
    output logic [$clog2(DEPTH+1)-1:0] o_q_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_inflight_pc;
    logic          r_inflight;
    logic [31:0]   r_pc    [DEPTH];
    logic [31:0]   r_instr [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [CW:0]   w_occ;
    logic          w_push;
    logic          w_pop;
    // the outstanding fetch reserves a slot so a full queue can never be overrun
    always_comb begin
        w_occ        = {1'b0, r_count} + (CW+1)'(r_inflight);
        o_imem_req   = !rst && !i_redirect && (w_occ < (CW+1)'(DEPTH));
        o_imem_addr  = r_fetch_pc;
        w_push       = i_imem_rvalid && r_inflight && !i_redirect;
        o_ifid_valid = r_count != '0;
        w_pop        = o_ifid_valid && !i_stall && !i_redirect;
        o_ifid_pc    = o_ifid_valid ? r_pc[r_head] : 32'h0;
        o_ifid_npc   = o_ifid_pc + 32'd4;
        o_ifid_instr = o_ifid_valid ? r_instr[r_head] : NOP;
        o_q_count    = r_count;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight_pc <= 32'h0;
            r_inflight    <= 1'b0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
        end else begin
            r_inflight    <= o_imem_req;
            r_inflight_pc <= o_imem_req ? r_fetch_pc : r_inflight_pc;
            r_fetch_pc    <= i_redirect ? i_redirect_pc : o_imem_req ? r_fetch_pc + 32'd4 : r_fetch_pc;
            r_head        <= i_redirect ? '0 : r_head + AW'(w_pop);
            r_tail        <= i_redirect ? '0 : r_tail + AW'(w_push);
            r_count       <= i_redirect ? '0 : r_count + CW'(w_push) - CW'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_tail]    <= r_inflight_pc;
            r_instr[r_tail] <= i_imem_rdata;
        end
    end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: scoreboard bench with 1-cycle memory model and random stall/redirect traffic
module tb_if_prefetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h00000013;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_rvalid = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_npc;
    logic [31:0] ifid_instr;
    logic [2:0]  q_count;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] pq[$];
    logic [31:0] aq[$];
    logic [31:0] p_nxt;
    logic [31:0] a_nxt;
    logic        pend = 1'b0;
    logic [31:0] pend_pc;
    logic        mem_req_d = 1'b0;
    logic [31:0] mem_addr_d = 32'h0;
    logic        spur_en = 1'b0;
    logic [31:0] hold_pc;

    if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .NOP(NOP)) dut (
        .clk(clk), .rst(rst),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr),
        .i_imem_rdata(imem_rdata), .i_imem_rvalid(imem_rvalid),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc), .i_stall(stall),
        .o_ifid_valid(ifid_valid), .o_ifid_pc(ifid_pc), .o_ifid_npc(ifid_npc),
        .o_ifid_instr(ifid_instr), .o_q_count(q_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a | 32'h00100000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic top_up();
        while (pq.size() < 16) begin pq.push_back(p_nxt); p_nxt += 32'd4; end
        while (aq.size() < 16) begin aq.push_back(a_nxt); a_nxt += 32'd4; end
    endtask

    task automatic reload(input logic [31:0] s);
        pq.delete();
        aq.delete();
        p_nxt = s;
        a_nxt = s;
        top_up();
    endtask

    task automatic step();
        @(posedge clk);
        if (pend) begin reload(pend_pc); pend = 1'b0; end
        top_up();
        #1;
        redirect = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        pend        = 1'b1;
        pend_pc     = pc;
    endtask

    // memory model: answers every accepted request one cycle later, else may emit stray beats
    always @(posedge clk) begin
        #1;
        if (mem_req_d) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem(mem_addr_d);
        end else begin
            imem_rvalid = spur_en && ($urandom_range(0, 4) == 0);
            imem_rdata  = $urandom;
        end
    end

    // monitor: every presented head must match the expected in-order pc stream
    always @(negedge clk) begin
        mem_req_d  = imem_req;
        mem_addr_d = imem_addr;
        if (!rst) begin
            if (ifid_valid) begin
                if (pq.size() == 0) begin
                    n_checks++;
                    $display("FAIL pc_stream: got %h with no expected entry", ifid_pc);
                end else begin
                    chk("head_pc", ifid_pc, pq[0]);
                    chk("head_npc", ifid_npc, pq[0] + 32'd4);
                    chk("head_instr", ifid_instr, mem(pq[0]));
                    if (!stall && !redirect) void'(pq.pop_front());
                end
            end else begin
                chk("idle_instr", ifid_instr, NOP);
                chk("idle_pc", ifid_pc, 32'h0);
            end
            if (imem_req) begin
                if (aq.size() == 0) begin
                    n_checks++;
                    $display("FAIL fetch_addr: got %h with no expected entry", imem_addr);
                end else begin
                    chk("fetch_addr", imem_addr, aq[0]);
                    void'(aq.pop_front());
                end
            end
            chk("qcount_bound", 32'(q_count <= 3'(DEPTH)), 32'h1);
        end
    end

    initial begin
        reload(32'h0);
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(ifid_valid), 32'h0);
        chk("rst_pc", ifid_pc, 32'h0);
        chk("rst_npc", ifid_npc, 32'h4);
        chk("rst_instr", ifid_instr, NOP);
        chk("rst_qcount", 32'(q_count), 32'h0);
        chk("rst_req", 32'(imem_req), 32'h0);
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("c0_req", 32'(imem_req), 32'h1);
        chk("c0_addr", imem_addr, 32'h0);
        chk("c0_valid", 32'(ifid_valid), 32'h0);
        step();
        @(negedge clk);
        chk("c1_valid", 32'(ifid_valid), 32'h0);
        step();
        @(negedge clk);
        chk("c2_valid", 32'(ifid_valid), 32'h1);
        chk("c2_pc", ifid_pc, 32'h0);
        chk("c2_npc", ifid_npc, 32'h4);
        chk("c2_instr", ifid_instr, 32'h00100000);
        repeat (10) begin
            step();
            @(negedge clk);
            chk("stream_nogap", 32'(ifid_valid), 32'h1);
            chk("stream_qcount_le2", 32'(q_count <= 3'd2), 32'h1);
        end
        step();
        stall = 1'b1;
        @(negedge clk);
        hold_pc = ifid_pc;
        repeat (8) step();
        @(negedge clk);
        chk("stall_full", 32'(q_count), 32'h4);
        chk("stall_noreq", 32'(imem_req), 32'h0);
        chk("stall_hold_pc", ifid_pc, hold_pc);
        step();
        stall = 1'b0;
        repeat (8) step();
        do_redirect(32'h200);
        @(negedge clk);
        chk("redir_rvalid_pop", 32'(imem_rvalid && ifid_valid && !stall), 32'h1);
        step();
        @(negedge clk);
        chk("redir_qcount", 32'(q_count), 32'h0);
        chk("redir_valid", 32'(ifid_valid), 32'h0);
        chk("redir_instr", ifid_instr, NOP);
        chk("redir_req_addr", imem_addr, 32'h200);
        step();
        step();
        @(negedge clk);
        chk("redir_first_valid", 32'(ifid_valid), 32'h1);
        chk("redir_first_pc", ifid_pc, 32'h200);
        step();
        @(negedge clk);
        chk("redir_second_pc", ifid_pc, 32'h204);
        step();
        do_redirect(32'hFFFFFFFC);
        step();
        step();
        step();
        @(negedge clk);
        chk("wrap_pc", ifid_pc, 32'hFFFFFFFC);
        chk("wrap_npc", ifid_npc, 32'h0);
        step();
        @(negedge clk);
        chk("wrap_next_pc", ifid_pc, 32'h0);
        spur_en = 1'b1;
        repeat (600) begin
            step();
            stall = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 19) == 0)
                do_redirect($urandom_range(0, 1) ? ($urandom & 32'hFFFFFFFC)
                                                 : 32'hFFFFFFF0 + 32'($urandom_range(0, 3)) * 32'd4);
        end
        step();
        stall = 1'b1;
        repeat (8) step();
        @(negedge clk);
        chk("pre_rst_full", 32'(q_count), 32'h4);
        step();
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(ifid_valid), 32'h0);
        chk("arst_pc", ifid_pc, 32'h0);
        chk("arst_npc", ifid_npc, 32'h4);
        chk("arst_instr", ifid_instr, NOP);
        chk("arst_qcount", 32'(q_count), 32'h0);
        chk("arst_req", 32'(imem_req), 32'h0);
        step();
        reload(32'h0);
        stall = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("restart_req", 32'(imem_req), 32'h1);
        chk("restart_addr", imem_addr, 32'h0);
        step();
        step();
        @(negedge clk);
        chk("restart_valid", 32'(ifid_valid), 32'h1);
        chk("restart_pc", ifid_pc, 32'h0);
        repeat (5) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
